// File: rtl/zx_line_fetch_if.sv
// Video memory read bus used by the ZX line fetcher.
//
// Signals:
//   req  - read request, held while a read is outstanding
//   addr - 13-bit byte offset within the screen page
//   ack  - read complete; data is valid in the same cycle
//   data - read data byte
//
// The fetcher is the master. The video memory arbiter is the slave.
interface zx_line_fetch_if;
    logic        req;
    logic [12:0] addr;
    logic        ack;
    logic [7:0]  data;

    modport master (
        output req,
        output addr,
        input  ack,
        input  data
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output data
    );
endinterface

// File: rtl/zx_line_fetch.sv
// ZX Spectrum line-buffered screen fetcher.
//
// While one scan line is being displayed, this block reads the bitmap and
// attribute bytes for the next line into one half of a double line buffer.
// Each line has 32 bitmap and 32 attribute bytes. The display side converts
// the other half into 4-bit-per-channel RGB, one pixel per pix_req. It applies
// border, bright and flash decoding.
//
// Ports:
//   clk, rst            - pixel clock; synchronous active-high reset
//   frame_start         - one-cycle pulse per frame; advances the flash counter
//   line_start          - one-cycle pulse per output line; swaps banks, starts fetch
//   line_num, line_vis  - line to fetch and fetch enable, sampled on line_start
//   mem                 - video memory read bus (req/addr/ack/data)
//   pix_req             - consumer takes the next pixel
//   border              - border colour, GRB order
//   pix_r/g/b           - registered pixel colour
//   underrun            - sticky flag, set when a fetch is cut short by line_start
module zx_line_fetch #(
    parameter logic [3:0] BORDER_LVL = 4'hA,
    parameter logic [3:0] BRIGHT_LVL = 4'hF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   line_start,
    input  logic [7:0]             line_num,
    input  logic                   line_vis,
    zx_line_fetch_if.master        mem,
    input  logic                   pix_req,
    input  logic [2:0]             border,
    output logic [3:0]             pix_r,
    output logic [3:0]             pix_g,
    output logic [3:0]             pix_b,
    output logic                   underrun
);

    typedef enum logic [1:0] {IDLE, BMP, ATTR, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic        wbank;
    logic [1:0]  valid;
    logic [4:0]  col;
    logic [7:0]  y;

    logic [7:0]  bmp_mem  [2][32];
    logic [7:0]  attr_mem [2][32];

    logic        fetch_en;
    logic        abort;
    logic        bmp_we;
    logic        attr_we;
    logic        fetch_done;

    logic [8:0]  pix_idx;
    logic [4:0]  flash_cnt;

    logic [8:0]  cur_p;
    logic        rd_bank;
    logic [7:0]  rd_bmp;
    logic [7:0]  rd_attr;
    logic        rd_bit;
    logic        ink_on;
    logic [2:0]  col_idx;
    logic [3:0]  col_lvl;

    // The ZX screen holds only 192 lines; anything beyond is never fetched.
    assign fetch_en = line_vis && (line_num < 8'd192);

    // Fetch state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. line_start overrides everything. An ack that lands in
    // the same cycle is dropped, because that bank is about to be displayed.
    always_comb begin
        state_next = state;
        abort      = 1'b0;
        bmp_we     = 1'b0;
        attr_we    = 1'b0;
        fetch_done = 1'b0;
        if (line_start) begin
            abort      = (state == BMP) || (state == ATTR);
            state_next = fetch_en ? BMP : IDLE;
        end else begin
            unique case (state)
                BMP: begin
                    if (mem.ack) begin
                        bmp_we     = 1'b1;
                        state_next = ATTR;
                    end
                end
                ATTR: begin
                    if (mem.ack) begin
                        attr_we = 1'b1;
                        if (col == 5'd31) begin
                            fetch_done = 1'b1;
                            state_next = DONE;
                        end else begin
                            state_next = BMP;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Request and address decode straight from the state register.
    // The address therefore cannot move while a read is pending.
    // The bitmap address interleaves the line number ZX-style:
    // third, pixel row, character row, column.
    always_comb begin
        mem.req  = 1'b0;
        mem.addr = 13'h0000;
        unique case (state)
            BMP: begin
                mem.req  = 1'b1;
                mem.addr = {y[7:6], y[2:0], y[5:3], col};
            end
            ATTR: begin
                mem.req  = 1'b1;
                mem.addr = 13'h1800 + {3'b000, y[7:3], col};
            end
            default: begin
            end
        endcase
    end

    // Bank bookkeeping. The bank about to be written loses its valid bit at
    // line start. An aborted or disabled line therefore shows as border.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbank    <= 1'b0;
            valid    <= 2'b00;
            col      <= 5'd0;
            y        <= 8'd0;
            underrun <= 1'b0;
        end else if (line_start) begin
            wbank         <= ~wbank;
            valid[~wbank] <= 1'b0;
            col           <= 5'd0;
            y             <= line_num;
            if (abort) begin
                underrun <= 1'b1;
            end
        end else if (attr_we) begin
            if (fetch_done) begin
                valid[wbank] <= 1'b1;
            end else begin
                col <= col + 5'd1;
            end
        end
    end

    // Line buffer storage. The contents need no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (bmp_we) begin
            bmp_mem[wbank][col] <= mem.data;
        end
        if (attr_we) begin
            attr_mem[wbank][col] <= mem.data;
        end
    end

    // A pixel requested in the same cycle as line_start already belongs to
    // the new line. It uses index 0 and the bank that has just finished loading.
    always_comb begin
        cur_p   = line_start ? 9'd0 : pix_idx;
        rd_bank = line_start ? wbank : ~wbank;
        rd_bmp  = bmp_mem[rd_bank][cur_p[7:3]];
        rd_attr = attr_mem[rd_bank][cur_p[7:3]];
        rd_bit  = rd_bmp[3'd7 - cur_p[2:0]];
        ink_on  = rd_bit ^ (rd_attr[7] & flash_cnt[4]);
        col_idx = border;
        col_lvl = BORDER_LVL;
        if (!cur_p[8] && valid[rd_bank]) begin
            col_idx = ink_on ? rd_attr[2:0] : rd_attr[5:3];
            col_lvl = rd_attr[6] ? BRIGHT_LVL : BORDER_LVL;
        end
    end

    // Display side. The pixel index saturates at 256, so pixels past the end
    // of the line fall back to border. Colour outputs hold between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_idx   <= 9'd256;
            flash_cnt <= 5'd0;
            pix_r     <= 4'h0;
            pix_g     <= 4'h0;
            pix_b     <= 4'h0;
        end else begin
            if (frame_start) begin
                flash_cnt <= flash_cnt + 5'd1;
            end
            if (pix_req) begin
                pix_g   <= col_idx[2] ? col_lvl : 4'h0;
                pix_r   <= col_idx[1] ? col_lvl : 4'h0;
                pix_b   <= col_idx[0] ? col_lvl : 4'h0;
                pix_idx <= cur_p[8] ? 9'd256 : cur_p + 9'd1;
            end else if (line_start) begin
                pix_idx <= 9'd0;
            end
        end
    end

endmodule

// File: tb/tb_zx_line_fetch.sv
// Directed testbench for zx_line_fetch.
//
// A video memory responder answers reads with programmable wait states. It
// logs every accepted address and watches that the address stays put while
// a read is waiting. The main sequence below walks through reset, fetch
// address order, rendering, border, flash, abort and mid-fetch reset.
//
// Hand-derived addresses ({y[7:6], y[2:0], y[5:3], col} and 0x1800 + {y[7:3], col}):
//   line 0x41 (01 000 001): bitmap 0x0900, attr 0x1900
//   line 0xBF (10 111 111): bitmap 0x17E0, attr 0x1AE0
//   line 0x42 (01 000 010): bitmap 0x0A00, attr 0x1900
module tb_zx_line_fetch;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic        line_start;
    logic [7:0]  line_num;
    logic        line_vis;
    logic        pix_req;
    logic [2:0]  border;
    logic [3:0]  pix_r;
    logic [3:0]  pix_g;
    logic [3:0]  pix_b;
    logic        underrun;

    zx_line_fetch_if mem_if ();

    zx_line_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .line_start  (line_start),
        .line_num    (line_num),
        .line_vis    (line_vis),
        .mem         (mem_if),
        .pix_req     (pix_req),
        .border      (border),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .underrun    (underrun)
    );

    int          checks;
    int          failures;

    logic [7:0]  mem_model [8192];
    logic [12:0] acc_q [$];
    int          req_cycles;
    int          stab_err;
    int          wait_max;
    int          wait_cnt;
    logic        ack_en;
    logic        idle_ack;
    logic        prev_wait;
    logic [12:0] prev_addr;

    logic [11:0] rgb;
    int          n;
    int          order_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Memory responder: decides ack/data at each falling edge.
    initial begin
        mem_if.ack  = 1'b0;
        mem_if.data = 8'h00;
        prev_wait   = 1'b0;
        prev_addr   = 13'h0;
        wait_cnt    = 0;
        forever begin
            @(negedge clk);
            if (mem_if.req && !rst) begin
                req_cycles++;
                if (prev_wait && (mem_if.addr !== prev_addr)) begin
                    stab_err++;
                end
                if (ack_en && wait_cnt == 0) begin
                    mem_if.ack  = 1'b1;
                    mem_if.data = mem_model[mem_if.addr];
                    acc_q.push_back(mem_if.addr);
                    wait_cnt    = $urandom_range(wait_max, 0);
                    prev_wait   = 1'b0;
                end else begin
                    mem_if.ack  = 1'b0;
                    mem_if.data = 8'hEE;
                    if (ack_en) begin
                        wait_cnt--;
                    end
                    prev_wait = 1'b1;
                    prev_addr = mem_if.addr;
                end
            end else begin
                mem_if.ack  = idle_ack;
                mem_if.data = 8'hEE;
                prev_wait   = 1'b0;
            end
            if (line_start || rst) begin
                prev_wait = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_line(input logic [7:0] num, input logic vis);
        line_num   = num;
        line_vis   = vis;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask

    task automatic get_pixel(output logic [11:0] col);
        pix_req = 1'b1;
        step();
        pix_req = 1'b0;
        col = {pix_r, pix_g, pix_b};
    endtask

    task automatic wait_fetch_done(input int budget, input string tag);
        int k;
        k = 0;
        while (mem_if.req && k < budget) begin
            step();
            k++;
        end
        check_output(tag, {15'b0, mem_if.req}, 16'h0000);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        req_cycles  = 0;
        stab_err    = 0;
        wait_max    = 0;
        ack_en      = 1'b1;
        idle_ack    = 1'b0;
        rst         = 1'b1;
        frame_start = 1'b0;
        line_start  = 1'b0;
        line_num    = 8'h00;
        line_vis    = 1'b0;
        pix_req     = 1'b0;
        border      = 3'b010;
        for (int i = 0; i < 8192; i++) begin
            mem_model[i] = 8'(i) ^ 8'h3C;
        end
        // Line 0x41: col 0 bitmap 0x80/attr 0x47, col 1 0x01/0x0A, col 31 0x01/0x61.
        mem_model[13'h0900] = 8'h80;
        mem_model[13'h1900] = 8'h47;
        mem_model[13'h0901] = 8'h01;
        mem_model[13'h1901] = 8'h0A;
        mem_model[13'h091F] = 8'h01;
        mem_model[13'h191F] = 8'h61;

        // Reset state.
        $display("[TB] reset");
        step();
        step();
        rst = 1'b0;
        check_output("rst_req", {15'b0, mem_if.req}, 16'h0000);
        check_output("rst_addr", {3'b0, mem_if.addr}, 16'h0000);
        check_output("rst_pix", {4'h0, pix_r, pix_g, pix_b}, 16'h0000);
        check_output("rst_underrun", {15'b0, underrun}, 16'h0000);
        get_pixel(rgb);
        check_output("rst_pix_border", {4'h0, rgb}, 16'h0A00);

        // Zero-wait fetch of line 0x41, ack also high while idle.
        $display("[TB] zero-wait fetch");
        idle_ack = 1'b1;
        acc_q.delete();
        req_cycles = 0;
        pulse_line(8'h41, 1'b1);
        wait_fetch_done(100, "zw_done");
        idle_ack = 1'b0;
        check_output("zw_req_cycles", 16'(req_cycles), 16'd64);
        check_output("zw_reads", 16'(acc_q.size()), 16'd64);
        check_output("zw_addr0", {3'b0, acc_q[0]}, 16'h0900);
        check_output("zw_addr1", {3'b0, acc_q[1]}, 16'h1900);
        check_output("zw_addr2", {3'b0, acc_q[2]}, 16'h0901);
        check_output("zw_addr63", {3'b0, acc_q[63]}, 16'h191F);

        // Random wait states, last visible line.
        $display("[TB] wait-state fetch");
        wait_max = 5;
        acc_q.delete();
        pulse_line(8'd191, 1'b1);
        wait_fetch_done(500, "ws_done");
        wait_max = 0;
        check_output("ws_reads", 16'(acc_q.size()), 16'd64);
        order_err = 0;
        for (int i = 0; i < acc_q.size(); i++) begin
            if (acc_q[i] !== ((i % 2 == 0) ? 13'h17E0 + 13'(i / 2) : 13'h1AE0 + 13'(i / 2))) begin
                order_err++;
            end
        end
        check_output("ws_order", 16'(order_err), 16'd0);
        check_output("ws_addr_stable", 16'(stab_err), 16'd0);

        // Render line 0x41.
        $display("[TB] render");
        pulse_line(8'h41, 1'b1);
        wait_fetch_done(100, "rd_done");
        pulse_line(8'h00, 1'b0);
        get_pixel(rgb);
        check_output("rd_pix0", {4'h0, rgb}, 16'h0FFF);
        get_pixel(rgb);
        check_output("rd_pix1", {4'h0, rgb}, 16'h0000);
        for (int i = 2; i < 8; i++) get_pixel(rgb);
        get_pixel(rgb);
        check_output("rd_pix8_paper", {4'h0, rgb}, 16'h000A);
        step();
        check_output("rd_hold", {4'h0, pix_r, pix_g, pix_b}, 16'h000A);
        for (int i = 9; i < 15; i++) get_pixel(rgb);
        get_pixel(rgb);
        check_output("rd_pix15_ink", {4'h0, rgb}, 16'h0A00);
        for (int i = 16; i < 255; i++) get_pixel(rgb);
        get_pixel(rgb);
        check_output("rd_pix255", {4'h0, rgb}, 16'h000F);
        get_pixel(rgb);
        check_output("rd_pix256_border", {4'h0, rgb}, 16'h0A00);
        get_pixel(rgb);
        check_output("rd_pix_sat_border", {4'h0, rgb}, 16'h0A00);

        // Border for invalid bank and for out-of-range line numbers.
        $display("[TB] border");
        pulse_line(8'h41, 1'b1);
        get_pixel(rgb);
        check_output("bd_invalid_bank", {4'h0, rgb}, 16'h0A00);
        wait_fetch_done(100, "bd_done");
        pulse_line(8'd200, 1'b1);
        check_output("bd_no_fetch_200", {15'b0, mem_if.req}, 16'h0000);
        get_pixel(rgb);
        check_output("bd_valid_pix0", {4'h0, rgb}, 16'h0FFF);
        pulse_line(8'h41, 1'b1);
        get_pixel(rgb);
        check_output("bd_line200_border", {4'h0, rgb}, 16'h0A00);
        wait_fetch_done(100, "bd_done2");

        // Flash.
        $display("[TB] flash");
        mem_model[13'h1900] = 8'hC7;
        pulse_line(8'h41, 1'b1);
        wait_fetch_done(100, "fl_done");
        for (int i = 0; i < 15; i++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
        end
        frame_start = 1'b1;
        line_num    = 8'h41;
        line_vis    = 1'b1;
        line_start  = 1'b1;
        pix_req     = 1'b1;
        step();
        frame_start = 1'b0;
        line_start  = 1'b0;
        check_output("fl_pix0_old_phase", {4'h0, pix_r, pix_g, pix_b}, 16'h0FFF);
        step();
        pix_req = 1'b0;
        check_output("fl_pix1_new_phase", {4'h0, pix_r, pix_g, pix_b}, 16'h0FFF);
        wait_fetch_done(100, "fl_done2");
        pulse_line(8'h41, 1'b1);
        get_pixel(rgb);
        check_output("fl_pix0_flashed", {4'h0, rgb}, 16'h0000);
        wait_fetch_done(100, "fl_done3");

        // Abort: ack withheld, then a new line arrives with an ack in the same cycle.
        $display("[TB] abort");
        ack_en = 1'b0;
        pulse_line(8'h41, 1'b1);
        step();
        step();
        check_output("ab_stalled_addr", {3'b0, mem_if.addr}, 16'h0900);
        check_output("ab_no_underrun_yet", {15'b0, underrun}, 16'h0000);
        ack_en = 1'b1;
        pulse_line(8'h42, 1'b1);
        acc_q.delete();
        check_output("ab_underrun", {15'b0, underrun}, 16'h0001);
        wait_fetch_done(100, "ab_done");
        check_output("ab_reads", 16'(acc_q.size()), 16'd64);
        check_output("ab_restart_addr0", {3'b0, acc_q[0]}, 16'h0A00);
        check_output("ab_restart_addr1", {3'b0, acc_q[1]}, 16'h1900);
        get_pixel(rgb);
        check_output("ab_border_line", {4'h0, rgb}, 16'h0A00);
        pulse_line(8'h41, 1'b0);
        check_output("ab_underrun_sticky", {15'b0, underrun}, 16'h0001);

        // Reset in the middle of a fetch, at column 10.
        $display("[TB] reset mid-fetch");
        pulse_line(8'h41, 1'b1);
        n = 0;
        while (!(mem_if.req && mem_if.addr == 13'h090A) && n < 100) begin
            step();
            n++;
        end
        check_output("mr_reached_col10", {3'b0, mem_if.addr}, 16'h090A);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("mr_req", {15'b0, mem_if.req}, 16'h0000);
        check_output("mr_addr", {3'b0, mem_if.addr}, 16'h0000);
        check_output("mr_pix", {4'h0, pix_r, pix_g, pix_b}, 16'h0000);
        check_output("mr_underrun", {15'b0, underrun}, 16'h0000);
        get_pixel(rgb);
        check_output("mr_pix_border", {4'h0, rgb}, 16'h0A00);
        pulse_line(8'h00, 1'b0);
        get_pixel(rgb);
        check_output("mr_valid_cleared", {4'h0, rgb}, 16'h0A00);
        check_output("final_addr_stable", 16'(stab_err), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
